// File: rtl/zeror_csr_master_if.sv
// Request, CSR-port and response signals of the CSR burst master.
// The master modport is the bridge's view; slave is the environment's view.
interface zeror_csr_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_op_i;
  logic [4:0]  req_len_i;
  logic        core_csr_busy_i;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [1:0]  csr_op_o;
  logic [31:0] csr_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_last_o;
  logic        busy_o;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_op_i, req_len_i,
    input  core_csr_busy_i, csr_rdata_i, rsp_ready_i,
    output req_ready_o, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
    output rsp_valid_o, rsp_rdata_o, rsp_last_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_op_i, req_len_i,
    output core_csr_busy_i, csr_rdata_i, rsp_ready_i,
    input  req_ready_o, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_last_o, busy_o
  );
endinterface

// File: rtl/zeror_csr_master.sv
// CSR burst master: turns one request into up to MAX_LEN single-cycle CSR
// port accesses at consecutive addresses, returning one response per beat.
//
// state | meaning
// IDLE  | ready for a new request
// ISSUE | waiting for the core to release the CSR port, then strobe once
// RESP  | holding the beat's read value until the consumer takes it
module zeror_csr_master #(
  parameter int MAX_LEN = 16
) (
  input logic               clk,
  input logic               rst,
  zeror_csr_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [4:0] LEN_CAP = 5'(MAX_LEN - 1);

  state_t      state;
  state_t      state_next;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [1:0]  op;
  logic [4:0]  count;
  logic [31:0] rdata;
  logic [4:0]  len_clamped;
  logic        accept;
  logic        strobe;
  logic        advance;
  logic        last;

  assign len_clamped = (bus.req_len_i > LEN_CAP) ? LEN_CAP : bus.req_len_i;
  assign last        = (count == 5'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and all handshake/port outputs.
  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    strobe           = 1'b0;
    advance          = 1'b0;
    bus.req_ready_o  = 1'b0;
    bus.csr_access_o = 1'b0;
    bus.csr_op_o     = OP_NONE;
    bus.csr_addr_o   = addr;
    bus.csr_wdata_o  = wdata;
    bus.rsp_valid_o  = 1'b0;
    bus.rsp_last_o   = 1'b0;
    bus.busy_o       = 1'b1;
    case (state)
      IDLE: begin
        bus.busy_o      = 1'b0;
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // The core pipeline has priority on the CSR port; wait as long as needed.
        strobe           = ~bus.core_csr_busy_i;
        bus.csr_access_o = strobe;
        if (strobe) begin
          bus.csr_op_o = op;
          state_next   = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_last_o  = last;
        if (bus.rsp_ready_i) begin
          advance    = ~last;
          state_next = last ? IDLE : ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, per-beat address/count stepping and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= 12'h000;
      wdata <= 32'h0;
      op    <= OP_NONE;
      count <= 5'd0;
      rdata <= 32'h0;
    end else begin
      if (accept) begin
        addr  <= bus.req_addr_i;
        wdata <= bus.req_wdata_i;
        op    <= bus.req_op_i;
        count <= len_clamped;
      end
      if (strobe) rdata <= bus.csr_rdata_i;
      if (advance) begin
        addr  <= addr + 12'h001;
        count <= count - 5'd1;
      end
    end
  end

  assign bus.rsp_rdata_o = rdata;

endmodule
